i2s_rx: RTL and testbench

Receive-side I2S deserializer for the audio codec's ADC path: it takes the codec-driven bit clock, word-select and serial ADC data, and recovers stereo sample pairs. It runs entirely in the 50 MHz fabric clock domain and treats the codec's bit clock and word select as sampled data, never as clocks. It is the capture-direction counterpart of the existing playback serializer. Its output is a valid/ready stereo frame interface toward the audio manager / SoC, plus a sticky overrun flag.

---
 rtl/i2s_rx.sv | 192 +++++++++++++++++++
 tb/tb_i2s_rx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S capture deserializer: oversamples the codec bit clock and word select in the
// fabric clock domain and presents complete stereo sample pairs on a valid/ready port.
module i2s_rx #(
  parameter int DATA_W      = 24,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              sclk,
  input  logic              lrclk,
  input  logic              adc_dat,
  output logic [DATA_W-1:0] left,
  output logic [DATA_W-1:0] right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic              locked
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYC);
  localparam logic [DATA_W-1:0] MSB_ONE  = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic [2:0]        sclk_pipe_q, sclk_pipe_d;
  logic [1:0]        lr_pipe_q, lr_pipe_d;
  logic [1:0]        dat_pipe_q, dat_pipe_d;
  logic              edge_q, edge_d;
  logic              lr_e_q, lr_e_d;
  logic              dat_e_q, dat_e_d;
  logic              ws_prev_q, ws_prev_d;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] sh_l_q, sh_l_d;
  logic [DATA_W-1:0] sh_r_q, sh_r_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              locked_q, locked_d;

  logic              rise_chg;
  logic              fall_chg;
  logic              capture;
  logic              complete;
  logic              timeout;
  logic [DATA_W-1:0] bit_mask;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    sclk_pipe_d = {sclk_pipe_q[1:0], sclk};
    lr_pipe_d   = {lr_pipe_q[0], lrclk};
    dat_pipe_d  = {dat_pipe_q[0], adc_dat};
    edge_d      = sclk_pipe_q[1] & ~sclk_pipe_q[2];
    lr_e_d      = lr_pipe_q[1];
    dat_e_d     = dat_pipe_q[1];

    rise_chg  = edge_q & lr_e_q & ~ws_prev_q;
    fall_chg  = edge_q & ~lr_e_q & ws_prev_q;
    ws_prev_d = edge_q ? lr_e_q : ws_prev_q;

    // Bits land MSB-first at their final position, so a short word is already left-aligned.
    capture  = edge_q && (state_q != ST_HUNT) && (bit_cnt_q < CNT_FULL);
    bit_mask = dat_e_q ? (MSB_ONE >> bit_cnt_q) : '0;

    timeout  = !edge_q && (to_cnt_q == TO_MAX);
    if (edge_q)                  to_cnt_d = '0;
    else if (to_cnt_q == TO_MAX) to_cnt_d = to_cnt_q;
    else                         to_cnt_d = to_cnt_q + TO_W'(1);

    state_d   = state_q;
    bit_cnt_d = capture ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
    sh_l_d    = sh_l_q;
    sh_r_d    = sh_r_q;
    complete  = 1'b0;

    case (state_q)
      ST_LEFT: begin
        if (capture) sh_l_d = sh_l_q | bit_mask;
        if (rise_chg) begin
          state_d   = ST_RIGHT;
          bit_cnt_d = '0;
          sh_r_d    = '0;
        end else if (fall_chg) begin
          bit_cnt_d = '0;
          sh_l_d    = '0;
        end
      end
      ST_RIGHT: begin
        // Once bit_cnt is full, capture stays low, so a word completes only once.
        if (capture) begin
          sh_r_d   = sh_r_q | bit_mask;
          complete = (bit_cnt_q == CNT_LAST) || fall_chg;
        end
        if (fall_chg) begin
          state_d   = ST_LEFT;
          bit_cnt_d = '0;
          sh_l_d    = '0;
        end
      end
      default: begin
        if (fall_chg) begin
          state_d   = ST_LEFT;
          bit_cnt_d = '0;
          sh_l_d    = '0;
        end
      end
    endcase

    left_d      = left_q;
    right_d     = right_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_clr ? 1'b0 : overrun_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        left_d      = sh_l_q;
        right_d     = sh_r_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // A stalled bit clock abandons partial words but leaves the held frame alone.
    if (timeout) begin
      state_d   = ST_HUNT;
      bit_cnt_d = '0;
      sh_l_d    = '0;
      sh_r_d    = '0;
    end

    locked_d = (state_d != ST_HUNT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sclk_pipe_q <= '0;
      lr_pipe_q   <= '0;
      dat_pipe_q  <= '0;
      edge_q      <= 1'b0;
      lr_e_q      <= 1'b0;
      dat_e_q     <= 1'b0;
      ws_prev_q   <= 1'b0;
      state_q     <= ST_HUNT;
      bit_cnt_q   <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      to_cnt_q    <= '0;
      left_q      <= '0;
      right_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      sclk_pipe_q <= sclk_pipe_d;
      lr_pipe_q   <= lr_pipe_d;
      dat_pipe_q  <= dat_pipe_d;
      edge_q      <= edge_d;
      lr_e_q      <= lr_e_d;
      dat_e_q     <= dat_e_d;
      ws_prev_q   <= ws_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
      to_cnt_q    <= to_cnt_d;
      left_q      <= left_d;
      right_q     <= right_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      locked_q    <= locked_d;
    end
  end

  assign left      = left_q;
  assign right     = right_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: table vectors, randomized frames against an
// arithmetic alignment model, and hand sequences for backpressure, timeout and reset.
module tb_i2s_rx;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        sclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        adc_dat = 1'b0;
  logic        out_ready = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [23:0] left;
  logic [23:0] right;
  logic        out_valid;
  logic        overrun;
  logic        locked;

  int checks = 0;
  int failures = 0;

  i2s_rx #(.DATA_W(24), .TIMEOUT_CYC(1024)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .sclk       (sclk),
    .lrclk      (lrclk),
    .adc_dat    (adc_dat),
    .left       (left),
    .right      (right),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .locked     (locked)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    int          s;
    logic [31:0] lw;
    logic [31:0] rw;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;

  vec_t        vecs[5];
  logic [1:0]  slots[$];    // {ws, dat} per sclk period
  logic        carry;
  logic [47:0] got_q[$];    // {left, right} of every accepted frame
  logic [47:0] exp_q[$];
  bit          mon_en = 1'b0;

  // Frames are recorded just before the edge that transfers them.
  always begin
    @(negedge CLK);
    #9;
    if (mon_en && out_valid && out_ready) got_q.push_back({left, right});
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic void start_stream();
    slots.delete();
    carry = 1'b0;
    slots.push_back(2'b10);
    slots.push_back(2'b10);
  endfunction

  // One word window: slot 0 carries the previous word's LSB, then this word MSB first.
  function automatic void push_window(input logic ws, input int s, input logic [31:0] word);
    logic [31:0] t;
    slots.push_back({ws, carry});
    for (int k = 1; k < s; k++) begin
      t = word >> (s - k);
      slots.push_back({ws, t[0]});
    end
    carry = word[0];
  endfunction

  function automatic void push_frame(input int s, input logic [31:0] lw, input logic [31:0] rw);
    push_window(1'b0, s, lw);
    push_window(1'b1, s, rw);
  endfunction

  function automatic void end_stream();
    slots.push_back({1'b0, carry});
    slots.push_back(2'b00);
  endfunction

  // Reference alignment: keep the top 24 bits of an s-bit word, zero-fill if shorter.
  function automatic logic [23:0] model_align(input int s, input logic [31:0] w);
    logic [31:0] t;
    if (s >= 24) t = w >> (s - 24);
    else         t = w << (24 - s);
    return t[23:0];
  endfunction

  // 8 CLK per slot (4 low, 4 high); optional one-cycle pulse on the completion cycle of a slot.
  task automatic drive_slots(input int pulse_idx, input bit pulse_clr);
    bit hold = 1'b0;
    for (int i = 0; i < slots.size(); i++) begin
      @(negedge CLK);
      if (hold) begin
        if (pulse_clr) overrun_clr = 1'b0;
        else           out_ready   = 1'b0;
        hold = 1'b0;
      end
      sclk    = 1'b0;
      lrclk   = slots[i][1];
      adc_dat = slots[i][0];
      repeat (4) @(negedge CLK);
      sclk = 1'b1;
      repeat (3) @(negedge CLK);
      if (i == pulse_idx) begin
        if (pulse_clr) overrun_clr = 1'b1;
        else           out_ready   = 1'b1;
        hold = 1'b1;
      end
    end
    @(negedge CLK);
    if (hold) begin
      if (pulse_clr) overrun_clr = 1'b0;
      else           out_ready   = 1'b0;
    end
    sclk = 1'b0;
  endtask

  task automatic do_reset();
    RESET       = 1'b1;
    sclk        = 1'b0;
    lrclk       = 1'b0;
    adc_dat     = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_one_frame(input string name, input logic [23:0] el, input logic [23:0] er);
    check({name, "_count"}, 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) begin
      check({name, "_left"}, 64'(got_q[0][47:24]), 64'(el));
      check({name, "_right"}, 64'(got_q[0][23:0]), 64'(er));
    end
  endtask

  initial begin
    vecs[0] = '{32, 32'hA5F00F00, 32'h12345600, 24'hA5F00F, 24'h123456};
    vecs[1] = '{16, 32'h0000BEEF, 32'h00008001, 24'hBEEF00, 24'h800100};
    vecs[2] = '{32, 32'hDEADBEEF, 32'h00000001, 24'hDEADBE, 24'h000000};
    vecs[3] = '{24, 32'h00800001, 32'h007FFFFE, 24'h800001, 24'h7FFFFE};
    vecs[4] = '{8,  32'h00000081, 32'h000000FF, 24'h810000, 24'hFF0000};

    do_reset();
    check("rst_left", 64'(left), 64'd0);
    check("rst_right", 64'(right), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);

    // Table vectors: one frame each from a fresh reset, consumer always ready.
    out_ready = 1'b1;
    mon_en    = 1'b1;
    for (int v = 0; v < 5; v++) begin
      do_reset();
      got_q.delete();
      check($sformatf("vec%0d_unlocked", v), 64'(locked), 64'd0);
      start_stream();
      push_frame(vecs[v].s, vecs[v].lw, vecs[v].rw);
      end_stream();
      drive_slots(-1, 1'b0);
      repeat (10) @(negedge CLK);
      check_one_frame($sformatf("vec%0d", v), vecs[v].el, vecs[v].er);
      check($sformatf("vec%0d_locked", v), 64'(locked), 64'd1);
    end

    // Randomized word lengths and data against the alignment model.
    do_reset();
    got_q.delete();
    exp_q.delete();
    start_stream();
    for (int f = 0; f < 6; f++) begin
      int          s;
      logic [31:0] lw;
      logic [31:0] rw;
      s  = int'($urandom_range(8, 32));
      lw = $urandom();
      rw = $urandom();
      if (s < 32) begin
        lw = lw & ((32'd1 << s) - 32'd1);
        rw = rw & ((32'd1 << s) - 32'd1);
      end
      push_frame(s, lw, rw);
      exp_q.push_back({model_align(s, lw), model_align(s, rw)});
    end
    end_stream();
    drive_slots(-1, 1'b0);
    repeat (10) @(negedge CLK);
    check("rand_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int f = 0; f < exp_q.size(); f++) begin
      if (f < got_q.size()) check($sformatf("rand_frame%0d", f), 64'(got_q[f]), 64'(exp_q[f]));
    end

    // Start mid-frame: reset released during a right word; only the next full frame appears.
    got_q.delete();
    RESET = 1'b1;
    start_stream();
    push_frame(32, 32'h55555555, 32'hAAAAAAAA);
    push_frame(32, 32'h3C3C3C00, 32'hC3C3C300);
    end_stream();
    fork
      drive_slots(-1, 1'b0);
      begin
        repeat (42 * 8) @(negedge CLK);
        RESET = 1'b0;
      end
    join
    repeat (10) @(negedge CLK);
    check_one_frame("midstart", 24'h3C3C3C, 24'hC3C3C3);

    // Backpressure: second frame dropped; overrun_clr on that same cycle loses to the set.
    mon_en    = 1'b0;
    out_ready = 1'b0;
    do_reset();
    start_stream();
    push_frame(32, 32'h00000100, 32'h00000200);
    push_frame(32, 32'h00000300, 32'h00000400);
    end_stream();
    drive_slots(2 + 64 + 32 + 24, 1'b1);
    repeat (10) @(negedge CLK);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_left", 64'(left), 64'd1);
    check("bp_right", 64'(right), 64'd2);
    check("bp_overrun", 64'(overrun), 64'd1);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    check("bp_overrun_sticky", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    @(negedge CLK);
    overrun_clr = 1'b0;
    check("bp_overrun_clr", 64'(overrun), 64'd0);

    // Accept and complete on the same cycle: frame 2 replaces frame 1 without overrun.
    do_reset();
    start_stream();
    push_frame(32, 32'h00000500, 32'h00000600);
    push_frame(32, 32'h00000900, 32'h00000A00);
    end_stream();
    drive_slots(2 + 64 + 32 + 24, 1'b0);
    repeat (10) @(negedge CLK);
    check("acc_valid", 64'(out_valid), 64'd1);
    check("acc_left", 64'(left), 64'd9);
    check("acc_right", 64'(right), 64'd10);
    check("acc_overrun", 64'(overrun), 64'd0);

    // Reset while a frame is held clears it immediately.
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_left", 64'(left), 64'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Timeout: stall mid-left, drop lock after the timeout, then a clean frame.
    mon_en    = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    start_stream();
    push_frame(32, 32'hFFFFFFFF, 32'hFFFFFFFF);
    while (slots.size() > 14) void'(slots.pop_back());
    drive_slots(-1, 1'b0);
    check("to_locked_before", 64'(locked), 64'd1);
    repeat (880) @(negedge CLK);
    check("to_locked_early", 64'(locked), 64'd1);
    repeat (220) @(negedge CLK);
    check("to_unlocked", 64'(locked), 64'd0);
    check("to_no_frame", 64'(got_q.size()), 64'd0);
    start_stream();
    push_frame(32, 32'h00000700, 32'h00000800);
    end_stream();
    drive_slots(-1, 1'b0);
    repeat (10) @(negedge CLK);
    check_one_frame("to_frame", 24'h000007, 24'h000008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
